// File: rtl/mm_seq_pkg.sv
// Shared constants and state encoding for the 4x4 GF(2^8) matrix-product sequencer.
package mm_seq_pkg;

    localparam int unsigned N            = 4;
    localparam int unsigned ISSUE_COUNT  = N * N * N;
    localparam int unsigned RESULT_COUNT = N * N;

    // Issue counter t = {i, j, k}, k innermost.
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned T_I_LSB = 4;
    localparam int unsigned T_J_LSB = 2;
    localparam int unsigned T_K_LSB = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

endpackage

// File: rtl/mm_operand_bank.sv
// 16-entry register file: one synchronous write port, one combinational read port.
module mm_operand_bank
    import mm_seq_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         we,
    input  logic [3:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [3:0]   raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem [RESULT_COUNT];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mm_sequencer.sv
// Streams A/B element pairs of a 4x4 matrix product into the serial MAC datapath
// and collects the 16 returned result bytes into a readable bank.
module mm_sequencer
    import mm_seq_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         wr_sel,
    input  logic [3:0]   wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic         start,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] mc,
    output logic [W-1:0] mi,
    output logic         op_valid,
    output logic         op_first,
    output logic         op_last,
    input  logic [W-1:0] prod_in,
    input  logic         prod_valid,
    input  logic [3:0]   rd_addr,
    output logic [W-1:0] rd_data
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e         state_q, state_d;
    logic [5:0]     t_q, t_d;
    logic [4:0]     r_q, r_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic           opv_q, opv_d;
    logic           opf_q, opf_d;
    logic           opl_q, opl_d;
    logic [W-1:0]   mc_q, mc_d;
    logic [W-1:0]   mi_q, mi_d;
    logic [W-1:0]   rd_q;

    logic [5:0]     t_iss;
    logic           iss;
    logic           cap;
    logic           idle;
    logic [3:0]     a_raddr, b_raddr;
    logic [W-1:0]   a_rdata, b_rdata, c_rdata;

    assign idle = (state_q == StIdle);
    assign cap  = prod_valid && !idle && (r_q < 5'(RESULT_COUNT));

    // Index of the pair loaded into the output registers at the next edge.
    always_comb begin
        t_iss = idle ? 6'd0 : t_q + 6'd1;
    end

    assign a_raddr = {t_iss[T_I_LSB +: IDX_W], t_iss[T_K_LSB +: IDX_W]};
    assign b_raddr = {t_iss[T_K_LSB +: IDX_W], t_iss[T_J_LSB +: IDX_W]};

    mm_operand_bank #(.W(W)) u_bank_a (
        .clk   (clk),
        .we    (wr_en && !wr_sel && idle),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (a_raddr),
        .rdata (a_rdata)
    );

    mm_operand_bank #(.W(W)) u_bank_b (
        .clk   (clk),
        .we    (wr_en && wr_sel && idle),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (b_raddr),
        .rdata (b_rdata)
    );

    mm_operand_bank #(.W(W)) u_bank_c (
        .clk   (clk),
        .we    (cap),
        .waddr (r_q[3:0]),
        .wdata (prod_in),
        .raddr (rd_addr),
        .rdata (c_rdata)
    );

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        r_d     = r_q;
        tmr_d   = tmr_q;
        err_d   = err_q;
        done_d  = 1'b0;
        iss     = 1'b0;
        opv_d   = 1'b0;
        opf_d   = 1'b0;
        opl_d   = 1'b0;
        mc_d    = mc_q;
        mi_d    = mi_q;

        if (cap) begin
            r_d = r_q + 5'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StRun;
                    t_d     = '0;
                    r_d     = '0;
                    tmr_d   = '0;
                    err_d   = 1'b0;
                    iss     = 1'b1;
                end
            end
            StRun: begin
                if (t_q == 6'(ISSUE_COUNT - 1)) begin
                    state_d = StDrain;
                end else begin
                    t_d = t_q + 6'd1;
                    iss = 1'b1;
                end
            end
            StDrain: begin
                tmr_d = cap ? '0 : tmr_q + 1'b1;
                // r_d covers the case where the last beat landed during RUN.
                if (r_d == 5'(RESULT_COUNT)) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (tmr_d == TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (iss) begin
            opv_d = 1'b1;
            opf_d = (t_iss[T_K_LSB +: IDX_W] == '0);
            opl_d = (t_iss[T_K_LSB +: IDX_W] == IDX_W'(N - 1));
            mc_d  = a_rdata;
            mi_d  = b_rdata;
        end

        if (abort) begin
            state_d = StIdle;
            err_d   = err_q;
            done_d  = 1'b0;
            opv_d   = 1'b0;
            opf_d   = 1'b0;
            opl_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            t_q     <= '0;
            r_q     <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            opv_q   <= 1'b0;
            opf_q   <= 1'b0;
            opl_q   <= 1'b0;
            mc_q    <= '0;
            mi_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            r_q     <= r_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            done_q  <= done_d;
            opv_q   <= opv_d;
            opf_q   <= opf_d;
            opl_q   <= opl_d;
            mc_q    <= mc_d;
            mi_q    <= mi_d;
            rd_q    <= c_rdata;
        end
    end

    assign busy     = !idle;
    assign done     = done_q;
    assign err      = err_q;
    assign mc       = mc_q;
    assign mi       = mi_q;
    assign op_valid = opv_q;
    assign op_first = opf_q;
    assign op_last  = opl_q;
    assign rd_data  = rd_q;

endmodule

// File: tb/tb_mm_sequencer.sv
// Directed bench for mm_sequencer with a GF(2^8) MAC responder standing in for the datapath.
module tb_mm_sequencer;

    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [7:0] mc;
        logic [7:0] mi;
        logic       first;
        logic       last;
    } pair_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } rd_vec_t;

    logic       clk, rst;
    logic       wr_en, wr_sel;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start, abort;
    logic       busy, done, err;
    logic [7:0] mc, mi;
    logic       op_valid, op_first, op_last;
    logic [7:0] prod_in;
    logic       prod_valid;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;

    mm_sequencer #(.W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mc         (mc),
        .mi         (mi),
        .op_valid   (op_valid),
        .op_first   (op_first),
        .op_last    (op_last),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Datapath model: one result byte the cycle after op_last, at most beat_limit per run.
    int         beat_limit = 16;
    int         beats;
    logic [7:0] acc;
    logic       pend_v;
    logic [7:0] pend_d;

    initial begin
        prod_valid = 1'b0;
        prod_in    = 8'h00;
        pend_v     = 1'b0;
        pend_d     = 8'h00;
        acc        = 8'h00;
        beats      = 0;
        forever begin
            @(posedge clk);
            #1;
            prod_valid = pend_v;
            prod_in    = pend_d;
            pend_v     = 1'b0;
            if (!busy) beats = 0;
            if (op_valid) begin
                acc = op_first ? gmul(mc, mi) : acc ^ gmul(mc, mi);
                if (op_last && beats < beat_limit) begin
                    pend_v = 1'b1;
                    pend_d = acc;
                    beats++;
                end
            end
        end
    end

    int      total = 0;
    int      bad = 0;
    int      n_pairs, done_cnt, last_cyc, done_cyc, drain_cyc;
    logic    err_at_done;
    pair_t   pair_log [8];
    pair_t   pair_vec [8];
    rd_vec_t rd_vec [16];

    logic [7:0] a_m [16] = '{8'd2, 8'd3, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd1,
                             8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd1, 8'd1, 8'd2};
    logic [7:0] b_m [16] = '{8'd14, 8'd11, 8'd13, 8'd9,  8'd9,  8'd14, 8'd11, 8'd13,
                             8'd13, 8'd9,  8'd14, 8'd11, 8'd11, 8'd13, 8'd9,  8'd14};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (op_valid) begin
            if (n_pairs < 8) pair_log[n_pairs] = '{mc, mi, op_first, op_last};
            n_pairs++;
            if (op_last) last_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc    = cyc;
            err_at_done = err;
        end
    endtask

    task automatic clear_mon();
        n_pairs     = 0;
        done_cnt    = 0;
        last_cyc    = -1;
        done_cyc    = -1;
        err_at_done = 1'b0;
    endtask

    task automatic wr(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr;
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        chk("done_seen", 32'(done_cnt > 0), 32'd1);
        repeat (4) step();
    endtask

    task automatic check_identity(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = rd_vec[i].addr;
            step();
            chk($sformatf("%s_c%0d", tag, i), 32'(rd_data), 32'(rd_vec[i].data));
        end
    endtask

    initial begin
        int n;

        pair_vec[0] = '{8'd2, 8'd14, 1'b1, 1'b0};
        pair_vec[1] = '{8'd3, 8'd9,  1'b0, 1'b0};
        pair_vec[2] = '{8'd1, 8'd13, 1'b0, 1'b0};
        pair_vec[3] = '{8'd1, 8'd11, 1'b0, 1'b1};
        pair_vec[4] = '{8'd2, 8'd11, 1'b1, 1'b0};
        pair_vec[5] = '{8'd3, 8'd14, 1'b0, 1'b0};
        pair_vec[6] = '{8'd1, 8'd9,  1'b0, 1'b0};
        pair_vec[7] = '{8'd1, 8'd13, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) begin
            rd_vec[i] = '{4'(i), (i % 5 == 0) ? 8'h01 : 8'h00};
        end

        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
        start = 1'b0; abort = 1'b0; rd_addr = 4'd0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 16; i++) wr(1'b0, 4'(i), a_m[i]);
        for (int i = 0; i < 16; i++) wr(1'b1, 4'(i), b_m[i]);

        // Identity product.
        clear_mon();
        do_start();
        wait_done(200);
        chk("id_pairs", 32'(n_pairs), 32'd64);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("id_pair%0d", i + 1), 32'(pair_log[i]), 32'(pair_vec[i]));
        end
        chk("id_done_once", 32'(done_cnt), 32'd1);
        chk("id_done_lat", 32'(done_cyc - last_cyc), 32'd2);
        chk("id_err", 32'(err_at_done), 32'd0);
        check_identity("id");

        // Abort at t=20, then rerun.
        clear_mon();
        do_start();
        n = 0;
        while (n_pairs < 21 && n < 100) begin
            step();
            n++;
        end
        chk("ab_t20_pair", 32'({mc, mi, op_first}), 32'({8'd1, 8'd11, 1'b1}));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_op_valid", 32'(op_valid), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        repeat (20) step();
        chk("ab_no_done", 32'(done_cnt), 32'd0);
        chk("ab_err", 32'(err), 32'd0);
        clear_mon();
        do_start();
        wait_done(200);
        chk("ab_rerun_pairs", 32'(n_pairs), 32'd64);
        chk("ab_rerun_pair1", 32'(pair_log[0]), 32'(pair_vec[0]));
        check_identity("ab");

        // Timeout: only 10 results come back.
        beat_limit = 10;
        clear_mon();
        do_start();
        n = 0;
        while (!(busy && !op_valid) && n < 100) begin
            step();
            n++;
        end
        drain_cyc = cyc;
        wait_done(100);
        chk("to_delay", 32'(done_cyc - drain_cyc), 32'(TIMEOUT));
        chk("to_err_at_done", 32'(err_at_done), 32'd1);
        chk("to_done_once", 32'(done_cnt), 32'd1);
        chk("to_err_sticky", 32'(err), 32'd1);
        beat_limit = 16;
        clear_mon();
        do_start();
        chk("to_err_cleared", 32'(err), 32'd0);
        wait_done(200);
        chk("to_rerun_err", 32'(err_at_done), 32'd0);

        // Write and start during RUN are ignored; then start in the done cycle.
        clear_mon();
        do_start();
        repeat (5) step();
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'hff; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 200) begin
            step();
            n++;
        end
        chk("pr_done", 32'(done_cnt), 32'd1);
        chk("pr_pairs", 32'(n_pairs), 32'd64);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_valid", 32'(op_valid), 32'd1);
        chk("b2b_pair", 32'({mc, mi, op_first}), 32'({8'd2, 8'd14, 1'b1}));
        clear_mon();
        wait_done(200);
        check_identity("pr");

        // Reset mid-run clears outputs without a clock edge.
        rd_addr = 4'd0;
        clear_mon();
        do_start();
        repeat (9) step();
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        chk("rst_mid_op_valid", 32'(op_valid), 32'd0);
        chk("rst_mid_mc_mi", 32'({mc, mi}), 32'd0);
        chk("rst_mid_rd_data", 32'(rd_data), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
